prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_prog_loader.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
//  Module   : prog_loader
//  Purpose  : UART-fed program loader for a small CPU. Receives framed
//             program images over a serial line and writes them into a
//             16x8 program memory that the CPU fetches from combinationally.
//             Frame: A5 sync, COUNT (1..16), ADDR (0..15), COUNT data bytes,
//             CSUM = 8-bit sum of COUNT, ADDR and data bytes.
//
//  Ports    : clk       - sole clock, rising edge
//             rst       - synchronous active-high reset
//             rxd       - UART serial input, idle high, asynchronous
//             rd_addr   - CPU program-fetch address
//             rd_data   - instruction byte at rd_addr (combinational)
//             cpu_hold  - high while a frame is in progress
//             load_done - one-cycle pulse on a successfully completed frame
//             load_err  - sticky error flag, cleared by the next sync byte
//
//  Revision : 1.0 - initial release
// ============================================================================
module prog_loader #(
    parameter int CLKS_PER_BIT = 234,
    parameter int TIMEOUT      = 65535
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    input  logic [3:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       cpu_hold,
    output logic       load_done,
    output logic       load_err
);

    localparam int W_CNT = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int W_TMR = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [W_CNT-1:0] c_bit_last  = W_CNT'(CLKS_PER_BIT - 1);
    localparam logic [W_CNT-1:0] c_half_last = W_CNT'(CLKS_PER_BIT / 2 - 1);
    localparam logic [W_TMR-1:0] c_timeout   = W_TMR'(TIMEOUT);
    localparam logic [7:0]       c_sync_byte = 8'hA5;

    // Receiver states
    localparam logic [1:0] c_rx_idle  = 2'd0;
    localparam logic [1:0] c_rx_start = 2'd1;
    localparam logic [1:0] c_rx_data  = 2'd2;
    localparam logic [1:0] c_rx_stop  = 2'd3;

    // Frame states
    localparam logic [2:0] S_SYNC = 3'd0;
    localparam logic [2:0] S_CNT  = 3'd1;
    localparam logic [2:0] S_ADDR = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_CSUM = 3'd4;

    // ------------------------------------------------------------------------
    // Program memory: no reset, so a CPU reset or loader reset never loses
    // the program image.
    // ------------------------------------------------------------------------
    logic [7:0] r_mem [16];
    logic       w_mem_we;

    assign rd_data = r_mem[rd_addr];

    // ------------------------------------------------------------------------
    // rxd synchronizer (idles high)
    // ------------------------------------------------------------------------
    logic r_rxd_meta;
    logic r_rxd_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rxd_meta <= 1'b1;
            r_rxd_sync <= 1'b1;
        end else begin
            r_rxd_meta <= rxd;
            r_rxd_sync <= r_rxd_meta;
        end
    end

    // ------------------------------------------------------------------------
    // UART receiver
    // ------------------------------------------------------------------------
    logic [1:0]       r_rx_state, w_rx_state_nxt;
    logic [W_CNT-1:0] r_rx_cnt,   w_rx_cnt_nxt;
    logic [2:0]       r_rx_idx,   w_rx_idx_nxt;
    logic [7:0]       r_rx_shift, w_rx_shift_nxt;
    logic             w_byte_valid;
    logic             w_frame_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_state <= c_rx_idle;
            r_rx_cnt   <= '0;
            r_rx_idx   <= '0;
            r_rx_shift <= '0;
        end else begin
            r_rx_state <= w_rx_state_nxt;
            r_rx_cnt   <= w_rx_cnt_nxt;
            r_rx_idx   <= w_rx_idx_nxt;
            r_rx_shift <= w_rx_shift_nxt;
        end
    end

    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_rx_cnt_nxt   = r_rx_cnt;
        w_rx_idx_nxt   = r_rx_idx;
        w_rx_shift_nxt = r_rx_shift;
        w_byte_valid   = 1'b0;
        w_frame_err    = 1'b0;
        case (r_rx_state)
            c_rx_idle: begin
                if (!r_rxd_sync) begin
                    w_rx_state_nxt = c_rx_start;
                    w_rx_cnt_nxt   = '0;
                end
            end
            c_rx_start: begin
                // Half-bit resample: a line that is high again was a glitch.
                if (r_rx_cnt == c_half_last) begin
                    w_rx_cnt_nxt   = '0;
                    w_rx_idx_nxt   = '0;
                    w_rx_state_nxt = r_rxd_sync ? c_rx_idle : c_rx_data;
                end else begin
                    w_rx_cnt_nxt = r_rx_cnt + 1'b1;
                end
            end
            c_rx_data: begin
                if (r_rx_cnt == c_bit_last) begin
                    w_rx_cnt_nxt   = '0;
                    w_rx_shift_nxt = {r_rxd_sync, r_rx_shift[7:1]};  // LSB first
                    if (r_rx_idx == 3'd7) begin
                        w_rx_state_nxt = c_rx_stop;
                    end else begin
                        w_rx_idx_nxt = r_rx_idx + 3'd1;
                    end
                end else begin
                    w_rx_cnt_nxt = r_rx_cnt + 1'b1;
                end
            end
            c_rx_stop: begin
                if (r_rx_cnt == c_bit_last) begin
                    w_rx_cnt_nxt   = '0;
                    w_rx_state_nxt = c_rx_idle;
                    w_byte_valid   = r_rxd_sync;
                    w_frame_err    = !r_rxd_sync;
                end else begin
                    w_rx_cnt_nxt = r_rx_cnt + 1'b1;
                end
            end
            default: w_rx_state_nxt = c_rx_idle;
        endcase
    end

    // ------------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------------
    logic [2:0]       r_state,  w_state_nxt;
    logic             r_hold,   w_hold_nxt;
    logic             r_done,   w_done_nxt;
    logic             r_err,    w_err_nxt;
    logic [7:0]       r_sum,    w_sum_nxt;
    logic [3:0]       r_ptr,    w_ptr_nxt;
    logic [4:0]       r_remain, w_remain_nxt;
    logic [W_TMR-1:0] r_timer,  w_timer_nxt;
    logic             w_abort;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_SYNC;
            r_hold   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_sum    <= '0;
            r_ptr    <= '0;
            r_remain <= '0;
            r_timer  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_hold   <= w_hold_nxt;
            r_done   <= w_done_nxt;
            r_err    <= w_err_nxt;
            r_sum    <= w_sum_nxt;
            r_ptr    <= w_ptr_nxt;
            r_remain <= w_remain_nxt;
            r_timer  <= w_timer_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_hold_nxt   = r_hold;
        w_done_nxt   = 1'b0;
        w_err_nxt    = r_err;
        w_sum_nxt    = r_sum;
        w_ptr_nxt    = r_ptr;
        w_remain_nxt = r_remain;
        w_mem_we     = 1'b0;
        w_abort      = 1'b0;

        // Inter-byte idle timer, only meaningful inside a frame.
        if (r_state == S_SYNC || w_byte_valid) begin
            w_timer_nxt = '0;
        end else begin
            w_timer_nxt = r_timer + 1'b1;
        end

        case (r_state)
            S_SYNC: begin
                if (w_byte_valid && r_rx_shift == c_sync_byte) begin
                    w_state_nxt = S_CNT;
                    w_hold_nxt  = 1'b1;
                    w_err_nxt   = 1'b0;
                    w_sum_nxt   = '0;
                end
            end
            S_CNT: begin
                if (w_byte_valid) begin
                    if (r_rx_shift != 8'd0 && r_rx_shift <= 8'd16) begin
                        w_remain_nxt = r_rx_shift[4:0];
                        w_sum_nxt    = r_rx_shift;
                        w_state_nxt  = S_ADDR;
                    end else begin
                        w_abort = 1'b1;
                    end
                end
            end
            S_ADDR: begin
                if (w_byte_valid) begin
                    if (r_rx_shift[7:4] != 4'd0) begin
                        w_abort = 1'b1;
                    end else begin
                        w_ptr_nxt   = r_rx_shift[3:0];
                        w_sum_nxt   = r_sum + r_rx_shift;
                        w_state_nxt = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_byte_valid) begin
                    w_mem_we     = 1'b1;
                    w_ptr_nxt    = r_ptr + 4'd1;   // wraps 15 -> 0
                    w_sum_nxt    = r_sum + r_rx_shift;
                    w_remain_nxt = r_remain - 5'd1;
                    if (r_remain == 5'd1) begin
                        w_state_nxt = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                if (w_byte_valid) begin
                    if (r_rx_shift == r_sum) begin
                        w_done_nxt  = 1'b1;
                        w_hold_nxt  = 1'b0;
                        w_state_nxt = S_SYNC;
                    end else begin
                        w_abort = 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_SYNC;
        endcase

        // Framing error and idle timeout abort any frame in progress.
        if (r_state != S_SYNC &&
            (w_frame_err || (!w_byte_valid && r_timer == c_timeout))) begin
            w_abort = 1'b1;
        end

        if (w_abort) begin
            w_state_nxt = S_SYNC;
            w_hold_nxt  = 1'b0;
            w_err_nxt   = 1'b1;
            w_done_nxt  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_ptr] <= r_rx_shift;
        end
    end

    assign cpu_hold  = r_hold;
    assign load_done = r_done;
    assign load_err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prog_loader
//  Purpose  : Directed self-checking bench for prog_loader. Drives UART
//             frames on rxd and compares the loader flags and the program
//             memory (read through rd_addr/rd_data) against a reference
//             memory model kept by the bench.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

    localparam int CPB = 8;
    localparam int TMO = 200;

    logic       clk = 1'b0;
    logic       rst;
    logic       rxd;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic       cpu_hold;
    logic       load_done;
    logic       load_err;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    int overlap  = 0;

    logic [7:0] mem_m [16];
    logic       known [16];

    prog_loader #(
        .CLKS_PER_BIT (CPB),
        .TIMEOUT      (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .cpu_hold  (cpu_hold),
        .load_done (load_done),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (load_done) done_cnt++;
        if (load_done && load_err) overlap++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drives one UART character; leaves rxd high for a few clocks afterwards.
    task automatic send_byte(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        repeat (CPB) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
        rxd = stop;
        repeat (CPB) @(posedge clk);
        #1;
        rxd = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic tx(input logic [7:0] b);
        send_byte(b, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_wr(input logic [3:0] a, input logic [7:0] d);
        mem_m[a] = d;
        known[a] = 1'b1;
    endtask

    // Reads every address whose reference content is known.
    task automatic sweep_mem(input string tag);
        for (int a = 0; a < 16; a++) begin
            rd_addr = 4'(a);
            #1;
            if (known[a]) check($sformatf("%s mem[%0h]", tag, a), {24'd0, rd_data}, {24'd0, mem_m[a]});
        end
    endtask

    int d0;

    initial begin
        for (int a = 0; a < 16; a++) begin
            mem_m[a] = 8'h00;
            known[a] = 1'b0;
        end
        rxd     = 1'b1;
        rd_addr = 4'd0;
        rst     = 1'b1;
        idle(5);
        rst = 1'b0;
        idle(2);

        check("reset cpu_hold", {31'd0, cpu_hold}, 32'd0);
        check("reset load_done", {31'd0, load_done}, 32'd0);
        check("reset load_err", {31'd0, load_err}, 32'd0);

        // Basic load: A5 02 03 A1 90 36
        d0 = done_cnt;
        tx(8'hA5);
        check("basic hold after sync", {31'd0, cpu_hold}, 32'd1);
        tx(8'h02); tx(8'h03); tx(8'hA1); tx(8'h90);
        check("basic hold before csum", {31'd0, cpu_hold}, 32'd1);
        tx(8'h36);
        model_wr(4'h3, 8'hA1);
        model_wr(4'h4, 8'h90);
        check("basic done pulses", 32'(done_cnt - d0), 32'd1);
        check("basic load_err", {31'd0, load_err}, 32'd0);
        check("basic hold after csum", {31'd0, cpu_hold}, 32'd0);
        sweep_mem("basic");

        // Address wrap: A5 03 0E 11 22 33 77
        d0 = done_cnt;
        tx(8'hA5); tx(8'h03); tx(8'h0E); tx(8'h11); tx(8'h22); tx(8'h33); tx(8'h77);
        model_wr(4'hE, 8'h11);
        model_wr(4'hF, 8'h22);
        model_wr(4'h0, 8'h33);
        check("wrap done pulses", 32'(done_cnt - d0), 32'd1);
        check("wrap load_err", {31'd0, load_err}, 32'd0);
        sweep_mem("wrap");

        // Bad checksum: A5 01 00 55 00 (correct would be 56)
        d0 = done_cnt;
        tx(8'hA5); tx(8'h01); tx(8'h00); tx(8'h55); tx(8'h00);
        model_wr(4'h0, 8'h55);
        check("badsum no done", 32'(done_cnt - d0), 32'd0);
        check("badsum load_err", {31'd0, load_err}, 32'd1);
        check("badsum cpu_hold", {31'd0, cpu_hold}, 32'd0);
        sweep_mem("badsum");

        // Valid frame with a 3-clock glitch in the middle clears load_err:
        // A5 01 05 <glitch> 77 7D
        d0 = done_cnt;
        tx(8'hA5);
        check("glitch err cleared by sync", {31'd0, load_err}, 32'd0);
        tx(8'h01); tx(8'h05);
        rxd = 1'b0;
        idle(3);
        rxd = 1'b1;
        idle(20);
        tx(8'h77); tx(8'h7D);
        model_wr(4'h5, 8'h77);
        check("glitch done pulses", 32'(done_cnt - d0), 32'd1);
        check("glitch load_err", {31'd0, load_err}, 32'd0);
        sweep_mem("glitch");

        // Timeout: A5 02 then silence
        tx(8'hA5); tx(8'h02);
        check("timeout hold before", {31'd0, cpu_hold}, 32'd1);
        idle(300);
        check("timeout load_err", {31'd0, load_err}, 32'd1);
        check("timeout cpu_hold", {31'd0, cpu_hold}, 32'd0);
        // Back in S_SYNC: the next frame starts from the sync byte.
        d0 = done_cnt;
        tx(8'hA5); tx(8'h01); tx(8'h09); tx(8'hC3); tx(8'hCD);
        model_wr(4'h9, 8'hC3);
        check("post-timeout done", 32'(done_cnt - d0), 32'd1);
        check("post-timeout load_err", {31'd0, load_err}, 32'd0);
        sweep_mem("timeout");

        // Framing error in S_DATA: A5 02 06 12 <34 with stop=0>
        d0 = done_cnt;
        tx(8'hA5); tx(8'h02); tx(8'h06); tx(8'h12);
        send_byte(8'h34, 1'b0);
        idle(10);
        model_wr(4'h6, 8'h12);
        check("ferr no done", 32'(done_cnt - d0), 32'd0);
        check("ferr load_err", {31'd0, load_err}, 32'd1);
        check("ferr cpu_hold", {31'd0, cpu_hold}, 32'd0);
        sweep_mem("ferr");

        // Clear the error, then reset mid-frame: A5 01 then rst
        tx(8'hA5); tx(8'h01); tx(8'h07); tx(8'hEE); tx(8'hF6);
        model_wr(4'h7, 8'hEE);
        check("pre-rst load_err", {31'd0, load_err}, 32'd0);
        tx(8'hA5); tx(8'h01);
        check("pre-rst hold", {31'd0, cpu_hold}, 32'd1);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(2);
        check("rst load_err", {31'd0, load_err}, 32'd0);
        check("rst cpu_hold", {31'd0, cpu_hold}, 32'd0);
        sweep_mem("rst");

        // Loader fully usable after the reset: A5 02 0A 01 02 0F
        d0 = done_cnt;
        tx(8'hA5); tx(8'h02); tx(8'h0A); tx(8'h01); tx(8'h02); tx(8'h0F);
        model_wr(4'hA, 8'h01);
        model_wr(4'hB, 8'h02);
        check("post-rst done", 32'(done_cnt - d0), 32'd1);
        check("post-rst load_err", {31'd0, load_err}, 32'd0);
        sweep_mem("final");

        check("done/err overlap", 32'(overlap), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
